// File: rtl/spi_rx.sv
// SPI mode-3 receiver: 9-bit {dc, byte} words are queued in a first-word-fall-through
// FIFO for the CPU. The sticky ovf/ferr flags are cleared by clr.
module spi_rx #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            sck,
   input  logic            cs_,
   input  logic            sdi,
   input  logic            dc,
   input  logic            rd,
   input  logic            clr,
   output logic [8:0]      rdata,
   output logic            empty,
   output logic [ADDR_W:0] count,
   output logic            ovf,
   output logic            ferr
);

   // Input order {dc, sdi, cs_, sck}; sck and cs_ idle high.
   localparam logic [3:0] SYNC_INIT = 4'b0011;

   logic [3:0] pins;
   logic [3:0] sync1;
   logic [1:0] sync2;

   assign pins = {dc, sdi, cs_, sck};

   // sck and cs_ get a third stage for edge detection. sdi and dc are consumed
   // from the middle stage, which lines them up with the detected sck edge.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sync
         localparam int LEN = (gi < 2) ? 3 : 2;
         logic [LEN-1:0] chain_reg;
         always_ff @(posedge clk) begin
            if (reset) chain_reg <= {LEN{SYNC_INIT[gi]}};
            else       chain_reg <= {chain_reg[LEN-2:0], pins[gi]};
         end
         assign sync1[gi] = chain_reg[1];
         if (gi < 2) begin : g_edge
            assign sync2[gi] = chain_reg[LEN-1];
         end
      end
   endgenerate

   logic sck_s, cs_s, sdi_s, dc_s;
   logic sck_rise, cs_rise;

   assign sck_s    = sync1[0];
   assign cs_s     = sync1[1];
   assign sdi_s    = sync1[2];
   assign dc_s     = sync1[3];
   assign sck_rise = sck_s & ~sync2[0];
   assign cs_rise  = cs_s & ~sync2[1];

   logic [1:0] warm_reg;
   logic       armed_reg;
   logic [2:0] bit_cnt_reg;
   logic [6:0] sr_reg;
   logic       push;
   logic [8:0] push_data;
   logic       ferr_set;

   assign push      = armed_reg & ~cs_s & sck_rise & (bit_cnt_reg == 3'd7);
   assign push_data = {dc_s, sr_reg, sdi_s};
   assign ferr_set  = armed_reg & cs_rise & (bit_cnt_reg != 3'd0);

   // warm_reg keeps the reset-loaded chain contents from counting as a real cs_ high.
   always_ff @(posedge clk) begin
      if (reset) begin
         warm_reg    <= 2'b00;
         armed_reg   <= 1'b0;
         bit_cnt_reg <= 3'd0;
         sr_reg      <= 7'd0;
      end else begin
         warm_reg <= {warm_reg[0], 1'b1};
         if (warm_reg[1] && cs_s) armed_reg <= 1'b1;
         if (cs_s) begin
            bit_cnt_reg <= 3'd0;
         end else if (armed_reg && sck_rise) begin
            sr_reg      <= {sr_reg[5:0], sdi_s};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
         end
      end
   end

   logic [8:0]      mem [DEPTH];
   logic [ADDR_W:0] wptr_reg, rptr_reg, wptr_next, rptr_next, count_int;
   logic [8:0]      rdata_reg;
   logic            full, pop_ok, push_ok, ovf_set;
   logic            ovf_reg, ferr_reg;

   assign count_int = wptr_reg - rptr_reg;
   assign full      = (count_int == (ADDR_W + 1)'(DEPTH));
   assign pop_ok    = rd & (count_int != '0);
   assign push_ok   = push & (~full | pop_ok);
   assign ovf_set   = push & full & ~pop_ok;
   assign wptr_next = wptr_reg + {{ADDR_W{1'b0}}, push_ok};
   assign rptr_next = rptr_reg + {{ADDR_W{1'b0}}, pop_ok};

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr_reg[ADDR_W-1:0]] <= push_data;
   end

   // Head register; bypass when the new head is the word being written this cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_reg  <= '0;
         rptr_reg  <= '0;
         rdata_reg <= 9'd0;
      end else begin
         wptr_reg <= wptr_next;
         rptr_reg <= rptr_next;
         if (wptr_next == rptr_next)
            rdata_reg <= 9'd0;
         else if (push_ok && (rptr_next == wptr_reg))
            rdata_reg <= push_data;
         else
            rdata_reg <= mem[rptr_next[ADDR_W-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_reg  <= 1'b0;
         ferr_reg <= 1'b0;
      end else begin
         ovf_reg  <= ovf_set | (ovf_reg & ~clr);
         ferr_reg <= ferr_set | (ferr_reg & ~clr);
      end
   end

   assign rdata = rdata_reg;
   assign count = count_int;
   assign empty = (count_int == '0);
   assign ovf   = ovf_reg;
   assign ferr  = ferr_reg;

endmodule

// File: tb/tb_spi_rx.sv
// Bench for spi_rx: directed and random SPI traffic against a queue-level model
// of the receive FIFO, compared on every falling clk edge.
module tb_spi_rx;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic clk = 1'b0, reset = 1'b1, sck = 1'b1, cs_ = 1'b1, sdi = 1'b0, dc = 1'b0;
   logic rd = 1'b0, clr = 1'b0;
   logic [8:0]      rdata;
   logic            empty;
   logic [ADDR_W:0] count;
   logic            ovf, ferr;

   spi_rx #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .sck(sck), .cs_(cs_), .sdi(sdi), .dc(dc),
      .rd(rd), .clr(clr), .rdata(rdata), .empty(empty), .count(count),
      .ovf(ovf), .ferr(ferr)
   );

   always #8 clk = ~clk;

   int          n_checks = 0;
   int          n_fail = 0;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {EV_RESET, EV_CLR, EV_POP, EV_PUSH, EV_FERR} ev_kind_t;
   typedef struct {
      int unsigned due;
      ev_kind_t    kind;
      logic [8:0]  data;
   } ev_t;

   ev_t        evq[$];
   logic [8:0] mq[$];
   bit         m_ovf = 1'b0, m_ferr = 1'b0;

   function automatic void sched(int unsigned lat, ev_kind_t k, logic [8:0] d);
      ev_t e;
      e.due  = cyc + lat;
      e.kind = k;
      e.data = d;
      evq.push_back(e);
   endfunction

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void apply_kind(ev_kind_t k);
      int i = 0;
      while (i < evq.size()) begin
         if (evq[i].due <= cyc && evq[i].kind == k) begin
            case (k)
               EV_CLR:  begin m_ovf = 1'b0; m_ferr = 1'b0; end
               EV_POP:  if (mq.size() != 0) void'(mq.pop_front());
               EV_PUSH: if (mq.size() < DEPTH) mq.push_back(evq[i].data); else m_ovf = 1'b1;
               EV_FERR: m_ferr = 1'b1;
               default: ;
            endcase
            evq.delete(i);
         end else begin
            i++;
         end
      end
   endfunction

   // Reset empties everything, including words still in the synchronizers.
   function automatic void apply_cycle();
      bit do_reset = 1'b0;
      foreach (evq[i]) if (evq[i].kind == EV_RESET && evq[i].due <= cyc) do_reset = 1'b1;
      if (do_reset) begin
         evq.delete();
         mq.delete();
         m_ovf  = 1'b0;
         m_ferr = 1'b0;
      end
      apply_kind(EV_CLR);
      apply_kind(EV_POP);
      apply_kind(EV_PUSH);
      apply_kind(EV_FERR);
   endfunction

   always @(negedge clk) begin
      logic [8:0] head;
      apply_cycle();
      head = (mq.size() != 0) ? mq[0] : 9'h000;
      check("rdata", 32'(rdata), 32'(head));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("count", 32'(count), 32'(mq.size()));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("ferr", 32'(ferr), 32'(m_ferr));
   end

   task automatic wait_clk(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(logic [7:0] b, bit d, int h, bit push, bit pop_last);
      for (int i = 7; i >= 0; i--) begin
         sck = 1'b0; sdi = b[i]; dc = d;
         wait_clk(h);
         sck = 1'b1;
         if (i == 0 && push) sched(3, EV_PUSH, {d, b});
         if (i == 0 && pop_last) begin
            wait_clk(2);
            rd = 1'b1; sched(1, EV_POP, 9'h0);
            wait_clk(1);
            rd = 1'b0;
            wait_clk(h - 3);
         end else begin
            wait_clk(h);
         end
      end
   endtask

   task automatic send_bits(logic [7:0] b, int n, int h);
      for (int i = 7; i >= 8 - n; i--) begin
         sck = 1'b0; sdi = b[i];
         wait_clk(h);
         sck = 1'b1;
         wait_clk(h);
      end
   endtask

   task automatic cs_down(int h);
      cs_ = 1'b0;
      wait_clk(h);
   endtask

   task automatic cs_up(int h, bit partial);
      cs_ = 1'b1;
      if (partial) sched(3, EV_FERR, 9'h0);
      wait_clk(h);
   endtask

   task automatic pop();
      rd = 1'b1; sched(1, EV_POP, 9'h0);
      wait_clk(1);
      rd = 1'b0;
   endtask

   task automatic pulse_clr();
      clr = 1'b1; sched(1, EV_CLR, 9'h0);
      wait_clk(1);
      clr = 1'b0;
   endtask

   initial begin
      repeat (80000) @(posedge clk);
      $display("FAIL watchdog: bench still running at cycle %0d, expected finish", cyc);
      $fatal(1, "watchdog expired");
   end

   bit         rand_done = 1'b0;
   logic [8:0] b2b_exp [3];

   initial begin
      b2b_exp[0] = 9'h001; b2b_exp[1] = 9'h080; b2b_exp[2] = 9'h0FF;
      wait_clk(5);
      @(negedge clk);
      check("reset_rdata", 32'(rdata), 32'h0);
      check("reset_empty", 32'(empty), 32'h1);
      wait_clk(1);
      reset = 1'b0;
      wait_clk(10);

      // Single byte, dc=1, slow link
      cs_down(25);
      send_byte(8'hA5, 1'b1, 25, 1'b1, 1'b0);
      cs_up(25, 1'b0);
      @(negedge clk);
      check("t1_rdata", 32'(rdata), 32'h1A5);
      check("t1_empty", 32'(empty), 32'h0);
      check("t1_count", 32'(count), 32'h1);
      wait_clk(1);
      pop();
      @(negedge clk);
      check("t1_pop_rdata", 32'(rdata), 32'h0);
      check("t1_pop_empty", 32'(empty), 32'h1);
      wait_clk(1);

      // Back-to-back bytes under one cs_
      cs_down(5);
      send_byte(8'h01, 1'b0, 5, 1'b1, 1'b0);
      send_byte(8'h80, 1'b0, 5, 1'b1, 1'b0);
      send_byte(8'hFF, 1'b0, 5, 1'b1, 1'b0);
      cs_up(5, 1'b0);
      @(negedge clk);
      check("t2_count", 32'(count), 32'h3);
      wait_clk(1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t2_rdata", 32'(rdata), 32'(b2b_exp[i]));
         wait_clk(1);
         pop();
      end

      // Overflow: 17 bytes, no reads
      cs_down(5);
      for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b0, 4, 1'b1, 1'b0);
      cs_up(5, 1'b0);
      @(negedge clk);
      check("t3_count", 32'(count), 32'h10);
      check("t3_ovf", 32'(ovf), 32'h1);
      wait_clk(1);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("t3_rdata", 32'(rdata), 32'(i));
         wait_clk(1);
         pop();
      end
      @(negedge clk);
      check("t3_empty", 32'(empty), 32'h1);
      wait_clk(1);
      pulse_clr();
      @(negedge clk);
      check("t3_clr_ovf", 32'(ovf), 32'h0);
      wait_clk(1);

      // Push and pop on the same cycle while full
      cs_down(5);
      for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b0, 5, 1'b1, 1'b0);
      send_byte(8'h99, 1'b0, 5, 1'b1, 1'b1);
      cs_up(5, 1'b0);
      @(negedge clk);
      check("t4_count", 32'(count), 32'h10);
      check("t4_ovf", 32'(ovf), 32'h0);
      wait_clk(1);
      for (int i = 0; i < 15; i++) pop();
      @(negedge clk);
      check("t4_last", 32'(rdata), 32'h099);
      wait_clk(1);
      pop();

      // Framing error, recovery, clr coinciding with a new error
      cs_down(5);
      send_bits(8'hFF, 5, 5);
      cs_up(5, 1'b1);
      @(negedge clk);
      check("t5_ferr", 32'(ferr), 32'h1);
      check("t5_count", 32'(count), 32'h0);
      wait_clk(1);
      cs_down(5);
      send_byte(8'h3C, 1'b0, 5, 1'b1, 1'b0);
      cs_up(5, 1'b0);
      @(negedge clk);
      check("t5_rdata", 32'(rdata), 32'h03C);
      wait_clk(1);
      pulse_clr();
      @(negedge clk);
      check("t5_clr_ferr", 32'(ferr), 32'h0);
      wait_clk(1);
      cs_down(5);
      send_bits(8'h00, 3, 5);
      wait_clk(2);
      cs_ = 1'b1; sched(3, EV_FERR, 9'h0);
      wait_clk(2);
      clr = 1'b1; sched(1, EV_CLR, 9'h0);
      wait_clk(1);
      clr = 1'b0;
      @(negedge clk);
      check("t5_set_wins", 32'(ferr), 32'h1);
      wait_clk(5);

      // Reset mid-byte with data and ferr pending, then arming
      cs_down(5);
      send_bits(8'hF0, 4, 5);
      sck = 1'b0;
      reset = 1'b1; sched(1, EV_RESET, 9'h0);
      wait_clk(5);
      @(negedge clk);
      check("t6_rdata", 32'(rdata), 32'h0);
      check("t6_empty", 32'(empty), 32'h1);
      check("t6_count", 32'(count), 32'h0);
      check("t6_flags", 32'({ovf, ferr}), 32'h0);
      wait_clk(1);
      sck = 1'b1;
      wait_clk(1);
      reset = 1'b0;
      wait_clk(6);
      send_byte(8'hC3, 1'b0, 5, 1'b0, 1'b0);
      wait_clk(5);
      @(negedge clk);
      check("t6_disarmed", 32'(count), 32'h0);
      wait_clk(1);
      cs_up(10, 1'b0);
      cs_down(5);
      send_byte(8'h5A, 1'b0, 5, 1'b1, 1'b0);
      cs_up(5, 1'b0);
      @(negedge clk);
      check("t6_rdata_5a", 32'(rdata), 32'h05A);
      check("t6_ferr", 32'(ferr), 32'h0);
      wait_clk(1);

      // Random traffic with concurrent reads and clears
      fork
         begin
            for (int it = 0; it < 30; it++) begin
               int h = $urandom_range(3, 6);
               int nb = $urandom_range(1, 3);
               bit partial = ($urandom_range(0, 4) == 0);
               cs_down(h);
               for (int j = 0; j < nb; j++)
                  send_byte(8'($urandom), 1'($urandom), h, 1'b1, 1'b0);
               if (partial) send_bits(8'($urandom), $urandom_range(1, 7), h);
               cs_up(h, partial);
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               wait_clk($urandom_range(1, 20));
               if ($urandom_range(0, 9) == 0) pulse_clr();
               else pop();
            end
         end
      join
      wait_clk(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
